// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority encoder.
package prio_enc_pkg;

    localparam int unsigned MAX_N = 64;
    localparam int unsigned MAX_W = 6;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // One-hot of an index at maximum width; callers truncate to their own N.
    function automatic logic [MAX_N-1:0] onehot_of(input logic [MAX_W-1:0] idx);
        onehot_of = MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational first-set-bit search starting at start_i, ascending or descending modulo N.
module prio_find_first
    import prio_enc_pkg::*;
#(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    input  logic         dir_i,     // 1 = ascending, 0 = descending
    output logic         found_o,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] onehot_o
);

    logic [W-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest set bit wins; W-bit wrap gives mod N.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            pos = dir_i ? (start_i + W'(k)) : (start_i - W'(k));
            if (req_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

    assign onehot_o = found_o ? N'(onehot_of(MAX_W'(idx_o))) : '0;

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin arbitration and valid/ready on both sides.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] req,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         none
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic         none_q, none_d;
    logic [W-1:0] ptr_q, ptr_d;

    mode_e        mode_s;
    logic         accept;
    logic [W-1:0] ff_start;
    logic         ff_dir;
    logic         ff_found;
    logic [W-1:0] ff_idx;
    logic [N-1:0] ff_onehot;

    assign mode_s   = mode_e'(mode);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Fixed mode searches down from the top bit; round-robin searches up from ptr.
    assign ff_start = (mode_s == MODE_RR) ? ptr_q : W'(N - 1);
    assign ff_dir   = (mode_s == MODE_RR);

    prio_find_first #(.N(N)) u_find (
        .req_i    (req),
        .start_i  (ff_start),
        .dir_i    (ff_dir),
        .found_o  (ff_found),
        .idx_o    (ff_idx),
        .onehot_o (ff_onehot)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        onehot_d    = onehot_q;
        none_d      = none_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            idx_d       = ff_idx;
            onehot_d    = ff_onehot;
            none_d      = !ff_found;
            if ((mode_s == MODE_RR) && ff_found) begin
                ptr_d = ff_idx + W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            onehot_q    <= '0;
            none_q      <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            onehot_q    <= onehot_d;
            none_q      <= none_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign idx       = idx_q;
    assign onehot    = onehot_q;
    assign none      = none_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr at N = 8, 2, 16 and 64 against a behavioural arbitration model.
`timescale 1ns/1ps
module tb_prio_encoder_rr;

    typedef struct {
        int          idx;
        logic [63:0] oh;
        bit          none;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int unsigned NN = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 16 : 64;
        localparam int unsigned WW = $clog2(NN);

        logic          rst, in_valid, in_ready, mode, out_valid, out_ready, none;
        logic [NN-1:0] req, onehot;
        logic [WW-1:0] idx;

        exp_t exp_q[$];
        bit   m_valid, m_rstvals, fin, fin_done;
        int   m_ptr;

        prio_encoder_rr #(.N(NN)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .req       (req),
            .mode      (mode),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .idx       (idx),
            .onehot    (onehot),
            .none      (none)
        );

        // Arbitration rules: fixed = highest set bit; round-robin = first set bit at or after ptr, wrapping.
        function automatic void ref_enc(input logic [NN-1:0] r, input bit rr, input int p,
                                        output int ix, output bit nn);
            nn = 1'b1;
            ix = 0;
            if (rr) begin
                for (int k = 0; k < int'(NN); k++) begin
                    if (nn && r[(p + k) % int'(NN)]) begin
                        ix = (p + k) % int'(NN);
                        nn = 1'b0;
                    end
                end
            end else begin
                for (int k = int'(NN) - 1; k >= 0; k--) begin
                    if (nn && r[k]) begin
                        ix = k;
                        nn = 1'b0;
                    end
                end
            end
        endfunction

        // Drive one cycle of inputs and advance the model at the clock edge.
        task automatic cyc(input bit r, input bit v, input logic [NN-1:0] rq, input bit md, input bit ordy);
            exp_t e;
            int   ix;
            bit   nn;
            rst       = r;
            in_valid  = v;
            req       = rq;
            mode      = md;
            out_ready = ordy;
            @(posedge clk);
            if (r) begin
                m_valid   = 1'b0;
                m_ptr     = 0;
                m_rstvals = 1'b1;
                exp_q.delete();
            end else if (v && (!m_valid || ordy)) begin
                ref_enc(rq, md, m_ptr, ix, nn);
                e.idx  = ix;
                e.none = nn;
                e.oh   = nn ? 64'd0 : (64'd1 << ix);
                exp_q.push_back(e);
                if (md && !nn) m_ptr = (ix + 1) % int'(NN);
                m_valid   = 1'b1;
                m_rstvals = 1'b0;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            #1;
        endtask

        initial begin
            cyc(1, 0, '0, 0, 1);
            cyc(1, 0, '0, 0, 1);
            // Fixed mode one-hot walk at full throughput.
            for (int i = 0; i < int'(NN); i++) cyc(0, 1, NN'(64'd1 << i), 0, 1);
            cyc(0, 1, NN'(64'h5A5A_5A5A_5A5A_5AA6), 0, 1);
            cyc(0, 1, '0, 0, 1);
            // Round-robin rotation over all-ones, then a sparse vector.
            for (int i = 0; i < int'(NN) + 2; i++) cyc(0, 1, '1, 1, 1);
            cyc(0, 1, NN'(5), 1, 1);
            cyc(0, 1, NN'(5), 1, 1);
            // Backpressure: result held, new requests ignored, then same-edge replace.
            cyc(0, 1, NN'(8), 0, 1);
            for (int i = 0; i < 3; i++) cyc(0, 1, NN'({$urandom(), $urandom()}), 1, 0);
            cyc(0, 1, NN'({$urandom(), $urandom()}), 0, 1);
            // Reset with a pending round-robin result.
            cyc(0, 1, NN'(16), 1, 1);
            cyc(0, 0, '0, 0, 0);
            cyc(1, 0, '0, 0, 0);
            cyc(0, 1, '1, 1, 1);
            cyc(0, 1, '1, 1, 1);
            // Randomised traffic.
            for (int i = 0; i < 1500; i++) begin
                logic [63:0] rv;
                int          kind;
                rv   = {$urandom(), $urandom()};
                kind = $urandom_range(0, 7);
                if (kind == 0) rv = 64'd0;
                else if (kind == 1) rv = 64'd1 << $urandom_range(0, NN - 1);
                cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, NN'(rv),
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
            end
            for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 1);
            fin = 1'b1;
        end

        // Monitor: handshake against the model, results against the scoreboard head.
        always @(negedge clk) begin
            if (rst === 1'b0) begin
                chk($sformatf("N%0d_out_valid", NN), 64'(out_valid), 64'(m_valid));
                chk($sformatf("N%0d_in_ready", NN), 64'(in_ready), 64'(!m_valid || out_ready));
                if (m_rstvals) begin
                    chk($sformatf("N%0d_rst_idx", NN), 64'(idx), 64'd0);
                    chk($sformatf("N%0d_rst_onehot", NN), 64'(onehot), 64'd0);
                    chk($sformatf("N%0d_rst_none", NN), 64'(none), 64'd0);
                end
                if (out_valid) begin
                    chk($sformatf("N%0d_result_expected", NN), 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        chk($sformatf("N%0d_idx", NN), 64'(idx), 64'(exp_q[0].idx));
                        chk($sformatf("N%0d_onehot", NN), 64'(onehot), exp_q[0].oh);
                        chk($sformatf("N%0d_none", NN), 64'(none), 64'(exp_q[0].none));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                if (fin && !fin_done) begin
                    chk($sformatf("N%0d_drain_empty", NN), 64'(exp_q.size()), 64'd0);
                    fin_done = 1'b1;
                end
            end
        end
    end

    initial begin
        int t;
        for (t = 0; t < 60000; t++) begin
            @(posedge clk);
            if (g_inst[0].fin && g_inst[1].fin && g_inst[2].fin && g_inst[3].fin) break;
        end
        if (t >= 60000) begin
            $display("FAIL timeout waiting for stimulus to complete");
            $fatal(1, "timeout");
        end
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
